serial_frame_rx: RTL and testbench

SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

---
 rtl/serial_frame_pkg.sv | 17 +
 rtl/frame_sipo.sv | 22 ++
 rtl/serial_frame_rx.sv | 116 +++++++++++
 tb/tb_serial_frame_rx.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame receiver: line levels, FSM states, defaults.
package serial_frame_pkg;

    localparam int DATA_W_DEF = 8;

    localparam logic START_BIT  = 1'b1;
    localparam logic STOP_BIT   = 1'b0;
    localparam logic IDLE_LEVEL = 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

endpackage

// File: rtl/frame_sipo.sv
// Serial-in parallel-out shift register; new bits enter at the LSB so the first bit ends up as MSB.
module frame_sipo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         shift,
    input  logic         din,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (shift)
            q <= {q[W-2:0], din};
    end

endmodule

// File: rtl/serial_frame_rx.sv
// Receiver for start/data/parity/stop frames sampled one bit per clock, with a one-deep output register.
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int PARITY_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    input  logic              ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt;
    logic              par_acc;
    logic [DATA_W-1:0] payload;
    logic              sipo_clr, sipo_shift, stop_edge;
    logic              cnt_last, par_bad, stop_bad, frame_good;

    assign cnt_last   = (cnt == CNT_W'(DATA_W - 1));
    assign par_bad    = (PARITY_EN != 0) && par_acc;
    assign stop_bad   = (s_in != STOP_BIT);
    assign frame_good = !par_bad && !stop_bad;

    frame_sipo #(.W(DATA_W)) u_sipo (
        .clk   (clk),
        .rst   (rst),
        .clr   (sipo_clr),
        .shift (sipo_shift),
        .din   (s_in),
        .q     (payload)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        sipo_clr   = 1'b0;
        sipo_shift = 1'b0;
        stop_edge  = 1'b0;
        case (state)
            IDLE: begin
                if (s_in == START_BIT) begin
                    state_nx = DATA;
                    sipo_clr = 1'b1;
                end
            end
            DATA: begin
                sipo_shift = 1'b1;
                if (cnt_last)
                    state_nx = (PARITY_EN != 0) ? PARITY : STOP;
            end
            PARITY: state_nx = STOP;
            // A bad stop bit still returns to IDLE; it is never reused as a start bit.
            STOP: begin
                stop_edge = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Running XOR over data bits and the parity bit; nonzero at STOP means odd parity.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            par_acc <= 1'b0;
        end else if (sipo_clr) begin
            cnt     <= '0;
            par_acc <= 1'b0;
        end else if (state == DATA) begin
            cnt     <= cnt + 1'b1;
            par_acc <= par_acc ^ s_in;
        end else if (state == PARITY) begin
            par_acc <= par_acc ^ s_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            parity_err <= stop_edge && par_bad;
            frame_err  <= stop_edge && stop_bad;
            overrun    <= 1'b0;
            if (stop_edge && frame_good) begin
                if (!valid || ready) begin
                    data_out <= payload;
                    valid    <= 1'b1;
                end else begin
                    overrun  <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Randomized frame stream checked each cycle against a frame-level reference model.
module tb_serial_frame_rx;
    import serial_frame_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         s_in = 1'b0;
    logic         ready = 1'b0;
    logic [W-1:0] data_out;
    logic         valid, parity_err, frame_err, overrun;

    always #5 clk = ~clk;

    serial_frame_rx #(.DATA_W(W), .PARITY_EN(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_in       (s_in),
        .data_out   (data_out),
        .valid      (valid),
        .ready      (ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    typedef struct {
        bit         s;
        bit         rdy;
        bit         rst_lo;
        bit         stop;
        bit [W-1:0] pay;
        bit         pbad;
        bit         sbad;
    } cyc_t;

    cyc_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   chk_en = 1'b0;

    // Reference state: what the consumer should currently see.
    bit [W-1:0] m_data;
    bit         m_valid, m_perr, m_ferr, m_ovr;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        m_data = '0; m_valid = 0; m_perr = 0; m_ferr = 0; m_ovr = 0;
    endfunction

    // One clock edge: only frame completions and consumption matter at this level.
    function automatic void model_step(cyc_t c);
        m_perr = 0; m_ferr = 0; m_ovr = 0;
        if (c.stop) begin
            m_perr = c.pbad;
            m_ferr = c.sbad;
            if (!c.pbad && !c.sbad) begin
                if (!m_valid || c.rdy) begin
                    m_data  = c.pay;
                    m_valid = 1;
                end else begin
                    m_ovr = 1;
                end
            end else if (m_valid && c.rdy) begin
                m_valid = 0;
            end
        end else if (m_valid && c.rdy) begin
            m_valid = 0;
        end
    endfunction

    function automatic bit rdy_of(int mode, bit at_stop);
        case (mode)
            0: return 1'b0;
            1: return 1'b1;
            2: return bit'($urandom_range(0, 1));
            default: return at_stop;
        endcase
    endfunction

    task automatic push_bit(bit s, bit rdy);
        cyc_t c;
        c = '{default: 0};
        c.s = s; c.rdy = rdy;
        q.push_back(c);
    endtask

    task automatic add_frame(logic [W-1:0] pay, bit pbad, bit sbad, int gap, int mode);
        cyc_t c;
        for (int i = 0; i < gap; i++) push_bit(IDLE_LEVEL, rdy_of(mode, 0));
        push_bit(START_BIT, rdy_of(mode, 0));
        for (int i = W - 1; i >= 0; i--) push_bit(pay[i], rdy_of(mode, 0));
        push_bit((^pay) ^ pbad, rdy_of(mode, 0));
        c = '{default: 0};
        c.s = sbad ? !STOP_BIT : STOP_BIT;
        c.rdy = rdy_of(mode, 1);
        c.stop = 1; c.pay = pay; c.pbad = pbad; c.sbad = sbad;
        q.push_back(c);
    endtask

    task automatic add_reset();
        cyc_t c;
        c = '{default: 0};
        c.rst_lo = 1;
        c.s = bit'($urandom_range(0, 1));
        c.rdy = bit'($urandom_range(0, 1));
        q.push_back(c);
    endtask

    task automatic add_partial(logic [W-1:0] bits, int n);
        push_bit(START_BIT, 1'b0);
        for (int i = 0; i < n; i++) push_bit(bits[W-1-i], 1'b0);
        add_reset();
    endtask

    // Inputs change 1 time unit after a rising edge; the model advances on the edge.
    task automatic run_queue();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            s_in  = c.s;
            ready = c.rdy;
            if (c.rst_lo) begin
                rst = 1'b0;
                model_clear();
            end else begin
                rst = 1'b1;
            end
            @(posedge clk);
            if (c.rst_lo) model_clear();
            else          model_step(c);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en)
            chk("cycle", 32'({data_out, valid, parity_err, frame_err, overrun}),
                32'({m_data, m_valid, m_perr, m_ferr, m_ovr}));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        model_clear();
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", 32'(data_out), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_pulses", 32'({parity_err, frame_err, overrun}), 32'h0);

        // Good frame A5 with ready high.
        add_frame(8'hA5, 0, 0, 2, 1);
        run_queue();
        chk("good_data", 32'(data_out), 32'hA5);
        chk("good_valid", 32'(valid), 32'h1);
        chk("good_pulses", 32'({parity_err, frame_err, overrun}), 32'h0);
        chk("model_good", 32'(m_data), 32'hA5);

        // Parity error on 3C; gap with ready drains the previous word first.
        add_frame(8'h3C, 1, 0, 2, 1);
        run_queue();
        chk("perr_pulse", 32'(parity_err), 32'h1);
        chk("perr_valid", 32'(valid), 32'h0);
        chk("perr_data", 32'(data_out), 32'hA5);
        push_bit(IDLE_LEVEL, 1'b1);
        run_queue();
        chk("perr_oneshot", 32'(parity_err), 32'h0);

        // Frame error on 81, then 5A immediately after the bad stop bit.
        add_frame(8'h81, 0, 1, 1, 1);
        run_queue();
        chk("ferr_pulse", 32'({parity_err, frame_err}), 32'h1);
        chk("ferr_valid", 32'(valid), 32'h0);
        add_frame(8'h5A, 0, 0, 0, 1);
        run_queue();
        chk("after_ferr_data", 32'(data_out), 32'h5A);
        chk("after_ferr_valid", 32'(valid), 32'h1);

        // Back-to-back with ready low: second frame overruns.
        push_bit(IDLE_LEVEL, 1'b1);
        push_bit(IDLE_LEVEL, 1'b1);
        add_frame(8'hA5, 0, 0, 0, 0);
        add_frame(8'h0F, 0, 0, 0, 0);
        run_queue();
        chk("ovr_data", 32'(data_out), 32'hA5);
        chk("ovr_valid", 32'(valid), 32'h1);
        chk("ovr_pulse", 32'(overrun), 32'h1);
        push_bit(IDLE_LEVEL, 1'b1);
        run_queue();
        chk("ovr_consume", 32'(valid), 32'h0);
        chk("ovr_oneshot", 32'(overrun), 32'h0);

        // Consume and complete on the same edge.
        add_frame(8'hA5, 0, 0, 1, 0);
        add_frame(8'h0F, 0, 0, 0, 3);
        run_queue();
        chk("simul_data", 32'(data_out), 32'h0F);
        chk("simul_valid", 32'(valid), 32'h1);
        chk("simul_ovr", 32'(overrun), 32'h0);
        chk("model_simul", 32'(m_data), 32'h0F);

        // Reset after four data bits, then a full frame.
        push_bit(IDLE_LEVEL, 1'b1);
        push_bit(IDLE_LEVEL, 1'b1);
        add_partial(8'hC3, 4);
        run_queue();
        chk("midrst_outs", 32'({data_out, valid, parity_err, frame_err, overrun}), 32'h0);
        add_frame(8'hC3, 0, 0, 1, 1);
        run_queue();
        chk("midrst_data", 32'(data_out), 32'hC3);
        chk("midrst_valid", 32'(valid), 32'h1);

        // Random traffic.
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                push_bit(IDLE_LEVEL, 1'b0);
                add_partial(W'($urandom), $urandom_range(0, W - 1));
            end else begin
                add_frame(W'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                          $urandom_range(0, 3), $urandom_range(0, 3));
            end
            run_queue();
        end

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
